image_loader: RTL and testbench

- Writer side of the frame-buffer pixel path.
- Receives a byte stream of 8-bit R, G, B samples from the UART receiver.
- Truncates each sample to 6 bits and packs three samples into one 18-bit raw pixel, red in [17:12], green in [11:6], blue in [5:0].
- Writes pixels sequentially into the frame-buffer BRAM, from which the display path later reads raw pixels.

---
 rtl/image_loader.sv | 112 +++++++++++
 tb/tb_image_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// rtl/image_loader.sv - packs R,G,B byte stream into 18-bit pixels and writes them sequentially to the frame buffer
// Optional idle-timeout resynchronisation: define IMAGE_LOADER_TIMEOUT_EN.
module image_loader #(
    parameter int IMG_WIDTH      = 160,
    parameter int IMG_HEIGHT     = 120,
    parameter int ADDR_W         = 15,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [17:0]       wr_data,
    output logic              loading,
    output logic              frame_done
);

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam int               NUM_PIX   = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    logic [1:0]        channel;
    logic [ADDR_W-1:0] pix_cnt;
    logic [5:0]        red_hold;
    logic [5:0]        green_hold;
    logic              restart;

    // Only the top six bits of each sample reach the pixel.
    logic unused_lsbs;
    assign unused_lsbs = ^rx_data[1:0];

`ifdef IMAGE_LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        idle_counting;
    logic        timeout;

    assign idle_counting = !rx_valid && (loading || channel != CH_R);
    // Fire on the edge that ends the final idle cycle so a byte arriving
    // right after the limit already lands as a fresh R sample.
    assign timeout       = idle_counting && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign restart       = clear || timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (rx_valid || restart) begin
            idle_cnt <= '0;
        end else if (idle_counting) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign restart = clear;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            channel    <= CH_R;
            pix_cnt    <= '0;
            red_hold   <= '0;
            green_hold <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            loading    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (restart) begin
                // A byte coinciding with a restart is discarded on purpose.
                channel <= CH_R;
                pix_cnt <= '0;
                loading <= 1'b0;
            end else if (rx_valid) begin
                case (channel)
                    CH_R: begin
                        red_hold <= rx_data[7:2];
                        channel  <= CH_G;
                        loading  <= 1'b1;
                    end
                    CH_G: begin
                        green_hold <= rx_data[7:2];
                        channel    <= CH_B;
                    end
                    CH_B: begin
                        channel <= CH_R;
                        wr_en   <= 1'b1;
                        wr_addr <= pix_cnt;
                        wr_data <= {red_hold, green_hold, rx_data[7:2]};
                        if (pix_cnt == LAST_ADDR) begin
                            pix_cnt    <= '0;
                            frame_done <= 1'b1;
                            loading    <= 1'b0;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                    default: channel <= CH_R;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// tb/tb_image_loader.sv - directed self-checking bench for image_loader on a 4x2 frame
module tb_image_loader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_data;
    logic          loading;
    logic          frame_done;

    int num_checks = 0;
    int num_fails  = 0;

    image_loader #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .loading(loading),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one byte for one cycle; returns at the next negedge where the
    // registered response to that byte is visible.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        send(r);
        send(g);
        send(b);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  r6, g6, b6;
        logic [17:0] exp_d;

        // Reset state
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_loading", loading, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single pixel
        send(8'hFF);
        check("single_loading_after_r", loading, 1);
        send(8'h80);
        send(8'h04);
        check("single_wr_en", wr_en, 1);
        check("single_wr_addr", wr_addr, 0);
        check("single_wr_data", wr_data, 18'h3F801);
        check("single_loading", loading, 1);
        check("single_frame_done", frame_done, 0);
        @(negedge clk);
        check("single_wr_en_one_cycle", wr_en, 0);
        check("single_wr_data_hold", wr_data, 18'h3F801);

        // Full frame: pixel i carries samples {i, i+1, i+2} in the top six bits
        pulse_reset();
        for (int i = 0; i < W * H; i++) begin
            r6 = 6'(i);
            g6 = 6'(i + 1);
            b6 = 6'(i + 2);
            send_pixel({r6, 2'b01}, {g6, 2'b10}, {b6, 2'b11});
            exp_d = {r6, g6, b6};
            check($sformatf("frame_wr_en_%0d", i), wr_en, 1);
            check($sformatf("frame_wr_addr_%0d", i), wr_addr, 32'(i));
            check($sformatf("frame_wr_data_%0d", i), wr_data, exp_d);
            check($sformatf("frame_done_%0d", i), frame_done, (i == W * H - 1) ? 1 : 0);
            check($sformatf("frame_loading_%0d", i), loading, (i == W * H - 1) ? 0 : 1);
        end
        send_pixel(8'h10, 8'h20, 8'h30);
        check("frame_wrap_addr", wr_addr, 0);
        check("frame_wrap_done", frame_done, 0);

        // Back-to-back stream 0x00..0x08, rx_valid high every cycle
        pulse_reset();
        for (int j = 0; j <= 9; j++) begin
            check($sformatf("b2b_wr_en_%0d", j), wr_en, (j == 3 || j == 6 || j == 9) ? 1 : 0);
            if (j == 3) begin
                check("b2b_addr_0", wr_addr, 0);
                check("b2b_data_0", wr_data, 18'h00000);
            end
            if (j == 6) begin
                check("b2b_addr_1", wr_addr, 1);
                check("b2b_data_1", wr_data, 18'h00041);
            end
            if (j == 9) begin
                check("b2b_addr_2", wr_addr, 2);
                check("b2b_data_2", wr_data, 18'h01042);
            end
            if (j < 9) begin
                rx_data  = 8'(j);
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Mid-pixel clear: counter is at 3 from the stream above
        send(8'hFC);
        send(8'hFC);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_loading", loading, 0);
        check("clear_wr_en", wr_en, 0);
        send_pixel(8'h10, 8'h20, 8'h30);
        check("clear_wr_en_after", wr_en, 1);
        check("clear_wr_addr", wr_addr, 0);
        check("clear_wr_data", wr_data, 18'h0420C);

        // Clear coinciding with a blue byte suppresses the write
        send(8'h44);
        send(8'h48);
        clear    = 1'b1;
        rx_data  = 8'h4C;
        rx_valid = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        rx_valid = 1'b0;
        check("clear_blue_no_write", wr_en, 0);
        send_pixel(8'h08, 8'h0C, 8'h10);
        check("clear_blue_next_addr", wr_addr, 0);
        check("clear_blue_next_data", wr_data, 18'h020C4);

        // Asynchronous reset mid-frame
        pulse_reset();
        for (int i = 0; i < 5; i++) send_pixel(8'hFF, 8'hFF, 8'hFF);
        send(8'hFF);
        check("pre_areset_addr", wr_addr, 4);
        #2 reset = 1'b1;
        #1;
        check("areset_wr_addr", wr_addr, 0);
        check("areset_wr_data", wr_data, 0);
        check("areset_loading", loading, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_pixel(8'h04, 8'h08, 8'h0C);
        check("areset_next_wr_en", wr_en, 1);
        check("areset_next_addr", wr_addr, 0);
        check("areset_next_data", wr_data, 18'h01083);

        // Long idle after a partial pixel
        pulse_reset();
        send(8'h40);
        send(8'h40);
        repeat (50) @(negedge clk);
`ifdef IMAGE_LOADER_TIMEOUT_EN
        check("idle_loading", loading, 0);
        send_pixel(8'h08, 8'h0C, 8'h10);
        check("idle_wr_en", wr_en, 1);
        check("idle_wr_addr", wr_addr, 0);
        check("idle_wr_data", wr_data, 18'h020C4);
`else
        check("idle_loading", loading, 1);
        send(8'h08);
        check("idle_wr_en", wr_en, 1);
        check("idle_wr_addr", wr_addr, 0);
        check("idle_wr_data", wr_data, 18'h10402);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
